// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
// Holds the fetch address and advances it on accepted fetches. Exceptions,
// exception return and branch/jump redirects are applied in fixed priority.
// Also keeps the saved exception PC, a halt/resume FSM and a fetch counter.
module pc_gen #(
  parameter int                 WIDTH        = 32,
  parameter int                 INC          = 4,
  parameter int                 ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int                 COUNT_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [WIDTH-1:0]   fetch_pc,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_target,
  input  logic               exc_valid,
  input  logic [WIDTH-1:0]   exc_pc,
  input  logic               eret,
  input  logic               halt_req,
  input  logic               resume,
  output logic [WIDTH-1:0]   epc,
  output logic               addr_err,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  // Mask of the low address bits that must be zero. Built by shifting so
  // ALIGN_BITS=0 yields an all-zero mask instead of an illegal slice.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_epc;
  logic               r_addr_err;
  logic [COUNT_W-1:0] r_count;

  logic               w_fire;
  logic               w_misaligned;
  logic               w_bad_redirect;

  assign fetch_valid    = (r_state == S_RUN);
  assign halted         = (r_state == S_HALT);
  assign fetch_pc       = r_pc;
  assign epc            = r_epc;
  assign addr_err       = r_addr_err;
  assign fetch_count    = r_count;

  assign w_fire         = fetch_valid & fetch_ready;
  assign w_misaligned   = |(redirect_target & ALIGN_MASK);
  // A misaligned redirect only turns into an exception if nothing of higher
  // priority claimed this cycle; otherwise it is dropped like any redirect.
  assign w_bad_redirect = redirect_valid & w_misaligned & ~exc_valid & ~eret;

  // Halt/resume state machine; redirects and exceptions never change state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_RUN;
        S_RUN:   if (halt_req) r_state <= S_HALT;
        S_HALT:  if (resume && !halt_req) r_state <= S_RUN;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // PC / EPC update in priority order: exception, eret, redirect, fire.
  // A fire that coincides with a redirect still counts, but pc takes the
  // redirect value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_epc <= '0;
    end else if (exc_valid) begin
      r_pc  <= EXC_VECTOR;
      r_epc <= exc_pc;
    end else if (eret) begin
      r_pc  <= r_epc;
    end else if (redirect_valid && w_misaligned) begin
      r_pc  <= EXC_VECTOR;
      r_epc <= redirect_target;
    end else if (redirect_valid) begin
      r_pc  <= redirect_target;
    end else if (w_fire) begin
      r_pc  <= r_pc + WIDTH'(INC);
    end
  end

  // One-cycle alignment-error pulse following a converted redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_addr_err <= 1'b0;
    else       r_addr_err <= w_bad_redirect;
  end

  // Accepted-fetch counter, independent of redirects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (w_fire) r_count <= r_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen. A reference model pushes the
// expected post-edge outputs each cycle; they are popped and compared after
// the edge. Directed checks cover the listed scenarios; a second 8-bit
// instance covers address wrap.
module tb_pc_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, redirect_target, exc_pc, epc, fetch_count;
  logic        redirect_valid, exc_valid, eret, halt_req, resume;
  logic        addr_err, halted;

  logic        s_valid, s_ready, s_redir, s_exc, s_eret, s_halt, s_resume;
  logic        s_aerr, s_halted;
  logic [7:0]  s_pc, s_target, s_exc_pc, s_epc;
  logic [3:0]  s_cnt;

  always #5 clock = ~clock;

  pc_gen dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret),
    .halt_req(halt_req), .resume(resume),
    .epc(epc), .addr_err(addr_err), .halted(halted), .fetch_count(fetch_count)
  );

  pc_gen #(.WIDTH(8), .EXC_VECTOR(8'h80), .COUNT_W(4)) dut8 (
    .clock(clock), .reset(reset),
    .fetch_valid(s_valid), .fetch_ready(s_ready), .fetch_pc(s_pc),
    .redirect_valid(s_redir), .redirect_target(s_target),
    .exc_valid(s_exc), .exc_pc(s_exc_pc), .eret(s_eret),
    .halt_req(s_halt), .resume(s_resume),
    .epc(s_epc), .addr_err(s_aerr), .halted(s_halted), .fetch_count(s_cnt)
  );

  typedef struct {
    logic [31:0] pc, epc, cnt;
    logic        fv, hl, ae;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // model state: 0=BOOT 1=RUN 2=HALT
  int          m_state;
  logic [31:0] m_pc, m_epc, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_epc = 32'h0; m_cnt = 32'h0;
  endtask

  // Predict the effect of the next edge from the driven inputs, push it,
  // clock once, then pop and compare every output.
  task automatic cycle(input string tag);
    exp_t e;
    logic fire;
    fire = (m_state == 1) && fetch_ready;
    e.ae = 1'b0;
    if (exc_valid) begin
      m_pc = 32'h80; m_epc = exc_pc;
    end else if (eret) begin
      m_pc = m_epc;
    end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
      m_pc = 32'h80; m_epc = redirect_target; e.ae = 1'b1;
    end else if (redirect_valid) begin
      m_pc = redirect_target;
    end else if (fire) begin
      m_pc = m_pc + 32'd4;
    end
    if (fire) m_cnt = m_cnt + 32'd1;
    case (m_state)
      0:       m_state = 1;
      1:       if (halt_req) m_state = 2;
      default: if (resume && !halt_req) m_state = 1;
    endcase
    e.pc = m_pc; e.epc = m_epc; e.cnt = m_cnt;
    e.fv = (m_state == 1); e.hl = (m_state == 2);
    exp_q.push_back(e);
    @(posedge clock); #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"},  fetch_pc,          e.pc);
    chk({tag, ".epc"}, epc,               e.epc);
    chk({tag, ".cnt"}, fetch_count,       e.cnt);
    chk({tag, ".fv"},  32'(fetch_valid),  32'(e.fv));
    chk({tag, ".hl"},  32'(halted),       32'(e.hl));
    chk({tag, ".ae"},  32'(addr_err),     32'(e.ae));
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_valid = 1'b0; exc_pc = '0; eret = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"},   fetch_pc,           32'h0);
    chk({tag, ".epc"},  epc,                32'h0);
    chk({tag, ".fv"},   32'(fetch_valid),   32'h0);
    chk({tag, ".ae"},   32'(addr_err),      32'h0);
    chk({tag, ".hl"},   32'(halted),        32'h0);
    chk({tag, ".cnt"},  fetch_count,        32'h0);
    chk({tag, ".s_pc"}, 32'(s_pc),          32'h0);
    chk({tag, ".s_fv"}, 32'(s_valid),       32'h0);
  endtask

  initial begin
    idle_inputs();
    s_ready = 1'b0; s_redir = 1'b0; s_target = '0; s_exc = 1'b0; s_exc_pc = '0;
    s_eret = 1'b0; s_halt = 1'b0; s_resume = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // BOOT -> RUN: first valid fetch at the reset vector
    fetch_ready = 1'b1;
    cycle("boot");
    chk("first_pc", fetch_pc, 32'h0);
    chk("first_fv", 32'(fetch_valid), 32'h1);
    for (int i = 0; i < 4; i++) cycle($sformatf("run%0d", i));
    chk("count4", fetch_count, 32'd4);
    chk("pc10", fetch_pc, 32'h10);

    // stall: pc and count hold
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("stall%0d", i));
    chk("stall_pc", fetch_pc, 32'h10);
    fetch_ready = 1'b1;
    cycle("unstall");
    chk("pc14", fetch_pc, 32'h14);

    // exception beats redirect; then eret
    fetch_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h200; exc_valid = 1'b1; exc_pc = 32'h44;
    cycle("exc");
    chk("exc_pc", fetch_pc, 32'h80);
    chk("exc_epc", epc, 32'h44);
    idle_inputs(); eret = 1'b1;
    cycle("eret");
    chk("eret_pc", fetch_pc, 32'h44);

    // misaligned redirect -> exception with one-cycle addr_err
    idle_inputs(); redirect_valid = 1'b1; redirect_target = 32'h102;
    cycle("misal");
    chk("misal_pc", fetch_pc, 32'h80);
    chk("misal_epc", epc, 32'h102);
    chk("misal_ae", 32'(addr_err), 32'h1);
    idle_inputs();
    cycle("misal2");
    chk("ae_pulse", 32'(addr_err), 32'h0);

    // halt with fire at 0x20, redirect while halted, resume
    redirect_valid = 1'b1; redirect_target = 32'h20;
    cycle("to20");
    idle_inputs(); halt_req = 1'b1; fetch_ready = 1'b1;
    cycle("halt");
    chk("halt_fv", 32'(fetch_valid), 32'h0);
    chk("halt_hl", 32'(halted), 32'h1);
    chk("halt_pc", fetch_pc, 32'h24);
    idle_inputs(); redirect_valid = 1'b1; redirect_target = 32'h300;
    cycle("hredir");
    chk("hredir_pc", fetch_pc, 32'h300);
    idle_inputs(); resume = 1'b1;
    cycle("resume");
    chk("resume_fv", 32'(fetch_valid), 32'h1);
    chk("resume_pc", fetch_pc, 32'h300);

    // redirect coinciding with fire: counted, pc takes target
    idle_inputs(); fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400;
    cycle("redir_fire");
    chk("rf_pc", fetch_pc, 32'h400);

    // eret with exception in same cycle: exception wins
    idle_inputs(); eret = 1'b1; exc_valid = 1'b1; exc_pc = 32'h1234;
    cycle("exc_eret");
    chk("ee_epc", epc, 32'h1234);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      fetch_ready     = 1'($urandom_range(0, 1));
      halt_req        = ($urandom_range(0, 9) == 0);
      resume          = ($urandom_range(0, 2) == 0);
      exc_valid       = ($urandom_range(0, 11) == 0);
      exc_pc          = $urandom;
      eret            = ($urandom_range(0, 11) == 0);
      redirect_valid  = ($urandom_range(0, 5) == 0);
      redirect_target = 32'($urandom_range(0, 4095));
      cycle($sformatf("rnd%0d", i));
    end

    // 8-bit instance: address wraps past 0xFC
    idle_inputs();
    s_redir = 1'b1; s_target = 8'hFC;
    cycle("w8a");
    chk("w8_fc", 32'(s_pc), 32'hFC);
    s_redir = 1'b0; s_ready = 1'b1;
    cycle("w8b");
    chk("w8_wrap", 32'(s_pc), 32'h0);
    chk("w8_cnt", 32'(s_cnt), 32'h1);

    // asynchronous reset mid-run
    fetch_ready = 1'b1;
    cycle("prerst");
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    idle_inputs();
    cycle("reboot");
    chk("reboot_pc", fetch_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, replacing the plain write-enabled PC register. It holds the current fetch address, advances it on each accepted fetch, and applies redirects (branch/jump), exception entry and exception return with fixed priority. It also keeps an exception PC (EPC), a halt/resume state machine and a fetch counter. It sits between the control/hazard unit and instruction memory.

## Interface
- WIDTH, 32, address width in bits.
- INC, 4, byte increment per accepted fetch.
- ALIGN_BITS, 2, low address bits that must be zero; a non-zero value is a misaligned target.
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h00000080, PC value loaded on exception entry.
- COUNT_W, 32, fetch-counter width.

- clock  in  1  clock, rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- fetch_valid  out  1  fetch_pc is a valid fetch request.
- fetch_ready  in  1  instruction memory accepts the request; fire = fetch_valid & fetch_ready.
- fetch_pc  out  WIDTH  current fetch address (registered).
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  WIDTH  new PC for the redirect.
- exc_valid  in  1  exception raised.
- exc_pc  in  WIDTH  PC of the faulting instruction.
- eret  in  1  return from exception.
- halt_req  in  1  stop fetching.
- resume  in  1  restart fetching.
- epc  out  WIDTH  saved exception PC.
- addr_err  out  1  one-cycle pulse: a misaligned redirect was converted to an exception.
- halted  out  1  state is HALT.
- fetch_count  out  COUNT_W  number of accepted fetches.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT. BOOT goes to RUN on the next clock. RUN goes to HALT when halt_req=1. HALT goes to RUN when resume=1 and halt_req=0.
- fetch_valid = (state==RUN). halted = (state==HALT).
- PC update each clock, highest priority first:
  - exc_valid: pc <= EXC_VECTOR, epc <= exc_pc.
  - eret: pc <= epc.
  - redirect_valid with misaligned target (target[ALIGN_BITS-1:0] != 0): pc <= EXC_VECTOR, epc <= redirect_target, addr_err <= 1.
  - redirect_valid, aligned target: pc <= redirect_target.
  - fire: pc <= pc + INC, modulo 2^WIDTH (the all-ones region wraps to 0).
  - otherwise pc holds.
- Redirect, exception and eret are applied in every state, including BOOT and HALT. They do not change the state.
- A lower-priority request in the same cycle as a higher-priority one is dropped, not queued.
- eret in the same cycle as exc_valid: the exception wins and epc takes exc_pc.
- fetch_count increments by 1 on fire, wraps modulo 2^COUNT_W, and is unaffected by redirects.
- When a redirect or exception coincides with fire, the fetch at the old pc still counts as accepted, but pc takes the redirect value, not pc+INC.

## Timing
- Reset values: fetch_pc=RESET_VECTOR, epc=0, fetch_valid=0, addr_err=0, halted=0, fetch_count=0, state=BOOT.
- The first fetch_valid=1 occurs one clock after reset is released, with fetch_pc=RESET_VECTOR.
- Every update is registered:
  - the new fetch_pc is visible in the cycle after the request;
  - epc is visible in the cycle after exc_valid or a misaligned redirect;
  - addr_err is high for exactly one cycle, the one after the misaligned redirect.
- halt_req deasserts fetch_valid in the next cycle. The fetch fired in the same cycle as halt_req still advances the PC.
- While fetch_ready=0 with fetch_valid=1, fetch_pc is stable until a fire or a redirect.
- Reset asserted mid-operation returns everything to reset values immediately, independent of the clock.

## Test plan
- Reset release, fetch_ready=1 for 4 cycles -> fetch_pc 0,4,8,12 on successive valid cycles; fetch_count=4.
- fetch_ready=0 for 3 cycles at pc=0x10 -> fetch_pc stays 0x10, count unchanged; ready=1 -> 0x14 next cycle.
- redirect to 0x200 in the same cycle as exc_valid with exc_pc=0x44 -> fetch_pc=0x80, epc=0x44; eret later -> fetch_pc=0x44.
- redirect_target=0x102 -> fetch_pc=0x80, epc=0x102, addr_err pulses for 1 cycle.
- halt_req at pc=0x20 with fire -> next cycle fetch_valid=0, halted=1, pc=0x24; redirect to 0x300 while halted -> pc=0x300; resume -> fetch_valid=1 at 0x300.
- WIDTH=8 with pc=0xFC and fire -> fetch_pc=0x00; reset asserted mid-run -> all outputs return to reset values immediately.
